// File: rtl/uart_core.sv
// ---------------------------------------------------------------------------
// uart_core
//   Full-duplex 8N1 UART: 1 start bit, 8 data bits LSB first, 1 stop bit.
//   There is a one-byte transmit holding register and a one-byte receive
//   holding register. TX and RX run fully independently.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2 .. 65535)
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   din     in   [7:0] byte to transmit
//   wr_en   in   write request, accepted while wr_rdy=1
//   wr_rdy  out  transmitter idle, can accept a byte
//   tx      out  serial output, idles high
//   rx      in   serial input, idles high, asynchronous to clk
//   rd_en   in   read acknowledge, consumes the byte while rd_rdy=1
//   rd_rdy  out  received byte valid on dout
//   dout    out  [7:0] last received byte
// ---------------------------------------------------------------------------
module uart_core #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       wr_rdy,
    output logic       tx,
    input  logic       rx,
    input  logic       rd_en,
    output logic       rd_rdy,
    output logic [7:0] dout
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // The start bit is checked CLKS_PER_BIT/2 cycles after the falling edge.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Transmitter
    // -----------------------------------------------------------------------
    state_t           r_tx_state;
    state_t           w_tx_next;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             w_tx_bit_end;
    logic             w_tx_accept;

    assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
    assign w_tx_accept  = (r_tx_state == S_IDLE) && wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= S_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (wr_en) w_tx_next = S_START;
            S_START: if (w_tx_bit_end) w_tx_next = S_DATA;
            S_DATA:  if (w_tx_bit_end && (r_tx_bit == 3'd7)) w_tx_next = S_STOP;
            S_STOP:  if (w_tx_bit_end) w_tx_next = S_IDLE;
            default: w_tx_next = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state register, so reset forces the
    // line high without waiting for a clock edge.
    always_comb begin
        tx     = 1'b1;
        wr_rdy = 1'b0;
        case (r_tx_state)
            S_IDLE:  wr_rdy = 1'b1;
            S_START: tx     = 1'b0;
            S_DATA:  tx     = r_tx_shift[0];
            S_STOP:  tx     = 1'b1;
            default: tx     = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else if (w_tx_accept) begin
            r_tx_shift <= din;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else if (r_tx_state != S_IDLE) begin
            if (w_tx_bit_end) begin
                r_tx_cnt <= '0;
                if (r_tx_state == S_DATA) begin
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Receiver
    // -----------------------------------------------------------------------
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    state_t           r_rx_state;
    state_t           w_rx_next;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_rx_ferr;
    logic [7:0]       r_dout;
    logic             r_rd_rdy;
    logic             w_rx_fall;
    logic             w_rx_half;
    logic             w_rx_full;
    logic             w_rx_done;
    logic             w_rx_ferr_set;

    // Two-flop synchronizer; r_rx_prev gives the edge detector its history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;
    assign w_rx_half = (r_rx_cnt == HALF_LAST);
    assign w_rx_full = (r_rx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= S_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
            S_START: if (w_rx_half) w_rx_next = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_full && (r_rx_bit == 3'd7)) w_rx_next = S_STOP;
            S_STOP: begin
                // After a framing error, hold here until the line is high
                // again so the low stop bit is not taken as a new start.
                if (r_rx_ferr) begin
                    if (r_rx_sync) w_rx_next = S_IDLE;
                end else if (w_rx_full && r_rx_sync) begin
                    w_rx_next = S_IDLE;
                end
            end
            default: w_rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rx_done     = 1'b0;
        w_rx_ferr_set = 1'b0;
        if ((r_rx_state == S_STOP) && !r_rx_ferr && w_rx_full) begin
            w_rx_done     = r_rx_sync;
            w_rx_ferr_set = ~r_rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_ferr  <= 1'b0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_cnt  <= '0;
                    r_rx_bit  <= '0;
                    r_rx_ferr <= 1'b0;
                end
                S_START: begin
                    r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + 1'b1;
                end
                S_DATA: begin
                    if (w_rx_full) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rx_cnt <= w_rx_full ? '0 : r_rx_cnt + 1'b1;
                    if (w_rx_ferr_set) r_rx_ferr <= 1'b1;
                end
            endcase
        end
    end

    // A completed byte wins over a simultaneous read acknowledge, and
    // overwrites an unread byte (newest wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout   <= '0;
            r_rd_rdy <= 1'b0;
        end else if (w_rx_done) begin
            r_dout   <= r_rx_shift;
            r_rd_rdy <= 1'b1;
        end else if (rd_en && r_rd_rdy) begin
            r_rd_rdy <= 1'b0;
        end
    end

    assign dout   = r_dout;
    assign rd_rdy = r_rd_rdy;

endmodule

// File: tb/tb_uart_core.sv
// ---------------------------------------------------------------------------
// tb_uart_core
//   Two uart_core instances at CLKS_PER_BIT=2 with u1.tx -> u2.rx and
//   u2.tx -> u1.rx. u2.rx can be switched to a bench-driven line for
//   glitch, framing-error and overrun stimulus. Expected received bytes are
//   queued when written and popped when rd_rdy is seen.
// ---------------------------------------------------------------------------
module tb_uart_core;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din1, din2;
    logic       wr_en1, wr_en2, rd_en1, rd_en2;
    logic       wr_rdy1, wr_rdy2, tx1, tx2, rd_rdy1, rd_rdy2;
    logic [7:0] dout1, dout2;
    logic       sel, tb_rx, rx2;

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign rx2 = sel ? tb_rx : tx1;

    uart_core #(.CLKS_PER_BIT(N)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .wr_en(wr_en1), .wr_rdy(wr_rdy1),
        .tx(tx1), .rx(tx2), .rd_en(rd_en1), .rd_rdy(rd_rdy1), .dout(dout1)
    );

    uart_core #(.CLKS_PER_BIT(N)) u2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .wr_en(wr_en2), .wr_rdy(wr_rdy2),
        .tx(tx2), .rx(rx2), .rd_en(rd_en2), .rd_rdy(rd_rdy2), .dout(dout2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input int idx, input string tag);
        int k;
        k = 0;
        while ((((idx == 1) ? rd_rdy1 : rd_rdy2) !== 1'b1) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, ((idx == 1) ? rd_rdy1 : rd_rdy2)}, 32'd1);
    endtask

    task automatic sb_check(input int idx, input string tag);
        logic [31:0] e;
        logic [7:0]  d;
        if (idx == 1) begin
            d = dout1;
            if (q1.size() > 0) e = 32'(q1.pop_front()); else e = 32'hDEAD;
        end else begin
            d = dout2;
            if (q2.size() > 0) e = 32'(q2.pop_front()); else e = 32'hDEAD;
        end
        chk(tag, {24'd0, d}, e);
    endtask

    task automatic read_pulse(input int idx);
        if (idx == 1) rd_en1 = 1'b1; else rd_en2 = 1'b1;
        @(negedge clk);
        rd_en1 = 1'b0;
        rd_en2 = 1'b0;
    endtask

    // Drives one 10-bit frame on the bench line, bits[0] first.
    task automatic send_raw(input logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            tb_rx = bits[i];
            repeat (N) @(negedge clk);
        end
    endtask

    function automatic logic [9:0] frame(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    initial begin
        logic [9:0] f1, f2;
        int         k;

        rst_n = 1'b0; sel = 1'b0; tb_rx = 1'b1;
        din1 = 8'h00; din2 = 8'h00;
        wr_en1 = 1'b0; wr_en2 = 1'b0; rd_en1 = 1'b0; rd_en2 = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("reset_held", {tx1, wr_rdy1, rd_rdy1, dout1, tx2, wr_rdy2, rd_rdy2, dout2},
            {1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00});
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle", {tx1, wr_rdy1, rd_rdy1, dout1, tx2, wr_rdy2, rd_rdy2, dout2},
                {1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00});
        end

        // Cross-connected exchange, same-cycle writes
        din1 = 8'h7D; din2 = 8'h2F; wr_en1 = 1'b1; wr_en2 = 1'b1;
        q2.push_back(8'h7D); q1.push_back(8'h2F);
        f1 = frame(8'h7D); f2 = frame(8'h2F);
        for (int j = 0; j <= 20; j++) begin
            @(negedge clk);
            if (j == 0) begin wr_en1 = 1'b0; wr_en2 = 1'b0; end
            if (j < 20) begin
                chk("u1_tx_wave", {31'd0, tx1}, {31'd0, f1[j/2]});
                chk("u2_tx_wave", {31'd0, tx2}, {31'd0, f2[j/2]});
            end
            chk("u1_wr_rdy_timing", {31'd0, wr_rdy1}, (j < 20) ? 32'd0 : 32'd1);
            chk("u2_wr_rdy_timing", {31'd0, wr_rdy2}, (j < 20) ? 32'd0 : 32'd1);
        end
        wait_rdy(2, "u2_rd_rdy");
        wait_rdy(1, "u1_rd_rdy");
        sb_check(2, "u2_dout");
        sb_check(1, "u1_dout");

        // Read handshake
        read_pulse(2);
        chk("u2_rd_clear", {31'd0, rd_rdy2}, 32'd0);
        chk("u2_dout_kept", {24'd0, dout2}, 32'h7D);
        read_pulse(2);
        chk("u2_rd_idle_en", {31'd0, rd_rdy2}, 32'd0);
        chk("u2_dout_idle_en", {24'd0, dout2}, 32'h7D);
        read_pulse(1);
        chk("u1_rd_clear", {31'd0, rd_rdy1}, 32'd0);
        chk("u1_dout_kept", {24'd0, dout1}, 32'h2F);

        // Back-to-back frames with wr_en held, then an ignored mid-frame write
        din1 = 8'h55; wr_en1 = 1'b1; q2.push_back(8'h55);
        @(negedge clk);
        din1 = 8'hA3; q2.push_back(8'hA3);
        chk("b2b_busy", {31'd0, wr_rdy1}, 32'd0);
        k = 0;
        while ((wr_rdy1 !== 1'b1) && (k < 100)) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_rdy_gap", k, 32'd20);
        @(negedge clk);
        wr_en1 = 1'b0;
        chk("b2b_second_start", {tx1, wr_rdy1}, 2'b00);
        wait_rdy(2, "b2b_first_rdy");
        sb_check(2, "b2b_first_byte");
        read_pulse(2);
        repeat (4) @(negedge clk);
        din1 = 8'hFF; wr_en1 = 1'b1;
        chk("ignored_wr_busy", {31'd0, wr_rdy1}, 32'd0);
        @(negedge clk);
        wr_en1 = 1'b0;
        wait_rdy(2, "b2b_second_rdy");
        sb_check(2, "b2b_second_byte");
        read_pulse(2);
        repeat (60) @(negedge clk);
        chk("no_extra_frame", {tx1, wr_rdy1, rd_rdy2}, 3'b110);

        // Line errors on the bench-driven line
        tb_rx = 1'b1; sel = 1'b1;
        repeat (5) @(negedge clk);
        tb_rx = 1'b0;
        @(negedge clk);
        tb_rx = 1'b1;
        repeat (10) @(negedge clk);
        tb_rx = 1'b0;
        #2 tb_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_no_rx", {23'd0, rd_rdy2, dout2}, {23'd0, 1'b0, 8'hA3});
        send_raw({1'b0, 8'h3C, 1'b0});
        repeat (4) @(negedge clk);
        tb_rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("framing_err", {23'd0, rd_rdy2, dout2}, {23'd0, 1'b0, 8'hA3});
        send_raw(frame(8'h81));
        send_raw(frame(8'h4E));
        repeat (10) @(negedge clk);
        chk("overrun_newest", {23'd0, rd_rdy2, dout2}, {23'd0, 1'b1, 8'h4E});
        read_pulse(2);
        chk("overrun_consumed", {31'd0, rd_rdy2}, 32'd0);
        sel = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during TX data bit 3
        din1 = 8'h96; wr_en1 = 1'b1;
        @(negedge clk);
        wr_en1 = 1'b0;
        repeat (8) @(negedge clk);
        chk("bit3_before_reset", {31'd0, tx1}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset", {tx1, wr_rdy1, rd_rdy2, dout2}, {1'b1, 1'b1, 1'b0, 8'h00});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        din1 = 8'h5A; wr_en1 = 1'b1; q2.push_back(8'h5A);
        @(negedge clk);
        wr_en1 = 1'b0;
        wait_rdy(2, "post_reset_rdy");
        sb_check(2, "post_reset_byte");
        chk("sb_drained", q1.size() + q2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
